// File: rtl/pellet_pool_ctrl_pkg.sv
// Shared types and sizing for the player pellet pool.
package pellet_pkg;

  localparam int unsigned NUM_SLOTS = 16;
  localparam int unsigned IDX_W     = $clog2(NUM_SLOTS);
  localparam int unsigned SCREEN_W  = 640;
  localparam int unsigned SCREEN_H  = 480;

  typedef enum logic [1:0] {
    IDLE,
    SPAWN,
    UPDATE
  } pellet_state_t;

  typedef struct packed {
    logic        active;
    logic [10:0] x;
    logic [10:0] y;
  } pellet_t;

endpackage

// File: rtl/pellet_pool_ctrl_if.sv
// Player-side and renderer-side signals of the pellet pool controller.
interface pellet_pool_ctrl_if;

  logic                                frame_tick;
  logic                                shoot;
  logic [10:0]                         shooter_x;
  logic [10:0]                         shooter_y;
  logic [pellet_pkg::IDX_W-1:0]        rd_index;
  logic                                rd_active;
  logic [10:0]                         rd_x;
  logic [10:0]                         rd_y;
  logic [pellet_pkg::NUM_SLOTS-1:0]    active_mask;
  logic [4:0]                          active_count;
  logic                                busy;
  logic                                spawn_ack;
  logic                                shoot_drop;
  logic                                retire;
  logic                                frame_overrun;

  modport master (
    output frame_tick, shoot, shooter_x, shooter_y, rd_index,
    input  rd_active, rd_x, rd_y, active_mask, active_count, busy,
           spawn_ack, shoot_drop, retire, frame_overrun
  );

  modport slave (
    input  frame_tick, shoot, shooter_x, shooter_y, rd_index,
    output rd_active, rd_x, rd_y, active_mask, active_count, busy,
           spawn_ack, shoot_drop, retire, frame_overrun
  );

endinterface

// File: rtl/pellet_pool_ctrl_free_finder.sv
// Lowest-index free slot search over the pool's active mask.
module pellet_free_finder
  import pellet_pkg::*;
(
  input  logic [NUM_SLOTS-1:0] active_mask,
  output logic                 found,
  output logic [IDX_W-1:0]     free_idx
);

  // Scan high to low so the lowest free index is the last one written.
  always_comb begin
    found    = 1'b0;
    free_idx = '0;
    for (int unsigned i = NUM_SLOTS; i > 0; i--) begin
      if (!active_mask[i-1]) begin
        found    = 1'b1;
        free_idx = IDX_W'(i - 1);
      end
    end
  end

endmodule

// File: rtl/pellet_pool_ctrl.sv
// Pellet pool controller: spawns pellets on shoot, advances/retires them once per frame.
module pellet_pool_ctrl
  import pellet_pkg::*;
#(
  parameter logic [10:0] SPEED           = 11'd4,
  parameter logic [3:0]  COOLDOWN_FRAMES = 4'd8
) (
  input  logic               Clk,
  input  logic               Reset,
  pellet_pool_ctrl_if.slave  bus
);

  pellet_t          r_slots [NUM_SLOTS];
  pellet_state_t    r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_shoot_pend;
  logic             r_frame_pend;
  logic [3:0]       r_cooldown;
  logic             r_spawn_ack;
  logic             r_shoot_drop;
  logic             r_retire;
  logic             r_frame_overrun;

  logic [NUM_SLOTS-1:0] w_active_mask;
  logic [4:0]           w_active_count;
  logic                 w_found;
  logic [IDX_W-1:0]     w_free_idx;
  pellet_t              w_cur;

  always_comb begin
    w_active_mask = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) w_active_mask[i] = r_slots[i].active;
  end

  always_comb begin
    w_active_count = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++)
      w_active_count = w_active_count + 5'(w_active_mask[i]);
  end

  assign w_cur = r_slots[r_idx];

  pellet_free_finder u_free_finder (
    .active_mask (w_active_mask),
    .found       (w_found),
    .free_idx    (w_free_idx)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) r_slots[i] <= '0;
      r_state         <= IDLE;
      r_idx           <= '0;
      r_shoot_pend    <= 1'b0;
      r_frame_pend    <= 1'b0;
      r_cooldown      <= '0;
      r_spawn_ack     <= 1'b0;
      r_shoot_drop    <= 1'b0;
      r_retire        <= 1'b0;
      r_frame_overrun <= 1'b0;
    end else begin
      r_spawn_ack     <= 1'b0;
      r_shoot_drop    <= 1'b0;
      r_retire        <= 1'b0;
      r_frame_overrun <= 1'b0;

      if (bus.shoot && (r_cooldown == '0) && !r_shoot_pend) r_shoot_pend <= 1'b1;

      // A tick meeting an already-pending frame is dropped, even when IDLE consumes it this cycle.
      if (bus.frame_tick) begin
        if (r_frame_pend) r_frame_overrun <= 1'b1;
        else              r_frame_pend    <= 1'b1;
        if (r_cooldown != '0) r_cooldown <= r_cooldown - 4'd1;
      end

      case (r_state)
        IDLE: begin
          if (r_shoot_pend) begin
            r_state <= SPAWN;
          end else if (r_frame_pend) begin
            r_state      <= UPDATE;
            r_frame_pend <= 1'b0;
            r_idx        <= '0;
          end
        end

        SPAWN: begin
          if (w_found) begin
            r_slots[w_free_idx] <= '{active: 1'b1, x: bus.shooter_x, y: bus.shooter_y};
            r_spawn_ack         <= 1'b1;
            r_cooldown          <= COOLDOWN_FRAMES;
          end else begin
            r_shoot_drop <= 1'b1;
          end
          r_shoot_pend <= 1'b0;
          r_state      <= IDLE;
        end

        UPDATE: begin
          if (w_cur.active) begin
            if (w_cur.y < SPEED) begin
              r_slots[r_idx].active <= 1'b0;
              r_retire              <= 1'b1;
            end else begin
              r_slots[r_idx].y <= w_cur.y - SPEED;
            end
          end
          r_idx <= r_idx + 1'b1;
          if (r_idx == IDX_W'(NUM_SLOTS - 1)) r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rd_active     = r_slots[bus.rd_index].active;
  assign bus.rd_x          = r_slots[bus.rd_index].x;
  assign bus.rd_y          = r_slots[bus.rd_index].y;
  assign bus.active_mask   = w_active_mask;
  assign bus.active_count  = w_active_count;
  assign bus.busy          = (r_state == UPDATE);
  assign bus.spawn_ack     = r_spawn_ack;
  assign bus.shoot_drop    = r_shoot_drop;
  assign bus.retire        = r_retire;
  assign bus.frame_overrun = r_frame_overrun;

endmodule

// File: tb/tb_pellet_pool_ctrl.sv
// Directed bench for pellet_pool_ctrl: one default build, one zero-cooldown build.
module tb_pellet_pool_ctrl;
  import pellet_pkg::*;

  logic Clk;
  logic Reset;

  pellet_pool_ctrl_if b ();
  pellet_pool_ctrl_if c ();

  pellet_pool_ctrl #(.SPEED(11'd4), .COOLDOWN_FRAMES(4'd8)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (b.slave)
  );

  pellet_pool_ctrl #(.SPEED(11'd4), .COOLDOWN_FRAMES(4'd0)) dut0 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (c.slave)
  );

  initial begin
    Clk = 1'b0;
    forever #10 Clk = ~Clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int unsigned idx;
    int unsigned x;
    int unsigned y;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          m_act [NUM_SLOTS];
  int unsigned m_x   [NUM_SLOTS];
  int unsigned m_y   [NUM_SLOTS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < int'(NUM_SLOTS); i++) if (!m_act[i]) return i;
    return -1;
  endfunction

  task automatic model_pass(inout int ret);
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      if (m_act[i]) begin
        if (m_y[i] < 4) begin
          m_act[i] = 1'b0;
          ret++;
        end else begin
          m_y[i] = m_y[i] - 4;
        end
      end
    end
  endtask

  // Walks the read port over every slot within one clock period.
  task automatic check_pool(input string tag);
    int cnt = 0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      b.rd_index = IDX_W'(i);
      #1;
      chk({tag, "_act"}, b.rd_active, m_act[i]);
      if (m_act[i]) begin
        cnt++;
        chk({tag, "_x"}, b.rd_x, m_x[i]);
        chk({tag, "_y"}, b.rd_y, m_y[i]);
      end
    end
    chk({tag, "_count"}, b.active_count, cnt);
  endtask

  task automatic pop_and_check(input string tag, input logic [10:0] rx, input logic [10:0] ry,
                               input logic ra, output int unsigned idx);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
      idx = 0;
    end else begin
      e = sb_q.pop_front();
      idx = e.idx;
      chk({tag, "_active"}, ra, 1);
      chk({tag, "_x"}, rx, e.x);
      chk({tag, "_y"}, ry, e.y);
    end
  endtask

  task automatic do_shoot(input int unsigned x, input int unsigned y, input bit req_ok);
    int          lat = 0;
    int          slot;
    int unsigned idx;
    exp_t        e;
    b.shooter_x = 11'(x);
    b.shooter_y = 11'(y);
    b.shoot     = 1'b1;
    if (req_ok) begin
      slot = lowest_free();
      e = '{idx: slot, x: x, y: y};
      sb_q.push_back(e);
    end
    cyc();
    b.shoot = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (b.spawn_ack === 1'b1) begin
        lat = k;
        break;
      end
    end
    if (req_ok) begin
      chk("spawn_latency", lat, 2);
      b.rd_index = IDX_W'(sb_q.size() > 0 ? sb_q[0].idx : 0);
      #1;
      pop_and_check("spawn", b.rd_x, b.rd_y, b.rd_active, idx);
      m_act[idx] = 1'b1;
      m_x[idx]   = x;
      m_y[idx]   = y;
    end else begin
      chk("shoot_ignored", lat, 0);
    end
  endtask

  task automatic frame_pass(input string tag);
    int busy_cnt = 0;
    int ret      = 0;
    int exp_ret  = 0;
    b.frame_tick = 1'b1;
    cyc();
    b.frame_tick = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (b.retire === 1'b1) ret++;
      if (b.busy === 1'b1) busy_cnt++;
      else if (busy_cnt > 0) break;
    end
    model_pass(exp_ret);
    chk({tag, "_busy_cycles"}, busy_cnt, 16);
    chk({tag, "_retires"}, ret, exp_ret);
    check_pool(tag);
    cyc();
  endtask

  task automatic shoot0(input int unsigned x, input int unsigned y, input bit ok, input int unsigned slot);
    int unsigned idx;
    exp_t        e;
    c.shooter_x = 11'(x);
    c.shooter_y = 11'(y);
    c.shoot     = 1'b1;
    if (ok) begin
      e = '{idx: slot, x: x, y: y};
      sb_q.push_back(e);
    end
    cyc();
    c.shoot = 1'b0;
    cyc();
    cyc();
    chk("c_spawn_ack", c.spawn_ack, ok);
    chk("c_shoot_drop", c.shoot_drop, !ok);
    if (ok) begin
      c.rd_index = IDX_W'(slot);
      #1;
      pop_and_check("c_spawn", c.rd_x, c.rd_y, c.rd_active, idx);
      chk("c_spawn_slot", idx, slot);
    end
    cyc();
  endtask

  initial begin
    int          ret;
    int          exp_ret;
    int          run;
    int          runs[$];
    int          ovr;
    int          inj;
    bit          prev_busy;
    int          slot;
    int unsigned idx;
    exp_t        e;

    b.frame_tick = 1'b0; b.shoot = 1'b0; b.shooter_x = '0; b.shooter_y = '0; b.rd_index = '0;
    c.frame_tick = 1'b0; c.shoot = 1'b0; c.shooter_x = '0; c.shooter_y = '0; c.rd_index = '0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      m_act[i] = 1'b0; m_x[i] = 0; m_y[i] = 0;
    end

    Reset = 1'b1;
    repeat (3) cyc();
    Reset = 1'b0;
    cyc();
    chk("rst_busy", b.busy, 0);
    chk("rst_mask", b.active_mask, 0);
    chk("rst_spawn_ack", b.spawn_ack, 0);
    chk("rst_pulses", {b.shoot_drop, b.retire, b.frame_overrun}, 0);
    b.rd_index = '0;
    #1;
    chk("rst_rd", {b.rd_active, b.rd_x, b.rd_y}, 0);
    check_pool("rst");
    cyc();

    // Zero-cooldown build: fill, overflow, retire slot 5, reuse it.
    for (int i = 0; i < int'(NUM_SLOTS); i++) shoot0(10 * i + 5, (i == 5) ? 2 : 400, 1'b1, i);
    chk("c_full_mask", c.active_mask, 16'hffff);
    chk("c_full_count", c.active_count, 16);
    shoot0(600, 100, 1'b0, 0);
    chk("c_drop_mask", c.active_mask, 16'hffff);
    c.rd_index = '0;
    #1;
    chk("c_drop_slot0", {c.rd_x, c.rd_y}, {11'd5, 11'd400});
    c.frame_tick = 1'b1;
    cyc();
    c.frame_tick = 1'b0;
    ret = 0;
    for (int k = 0; k < 25; k++) begin
      cyc();
      if (c.retire === 1'b1) ret++;
    end
    chk("c_retire_cnt", ret, 1);
    chk("c_retire_mask", c.active_mask, 16'hffdf);
    chk("c_retire_count", c.active_count, 15);
    shoot0(321, 123, 1'b1, 5);
    chk("c_reuse_mask", c.active_mask, 16'hffff);

    // Default build: first spawn, cooldown window, motion.
    do_shoot(100, 300, 1'b1);
    check_pool("spawn0");
    cyc();
    do_shoot(111, 222, 1'b0);
    for (int f = 0; f < 7; f++) frame_pass("cool");
    do_shoot(111, 222, 1'b0);
    frame_pass("cool8");
    chk("slot0_y_268", m_y[0], 268);
    do_shoot(200, 400, 1'b1);
    check_pool("spawn1");
    cyc();

    // Retire path: pellet spawned at y=6.
    for (int f = 0; f < 8; f++) frame_pass("pre_ret");
    do_shoot(50, 6, 1'b1);
    frame_pass("ret_a");
    frame_pass("ret_b");
    chk("slot2_retired", b.active_mask[2], 0);
    for (int f = 0; f < 6; f++) frame_pass("pre_sim");

    // Shoot and tick together in IDLE, then extra ticks during the pass.
    slot = lowest_free();
    e = '{idx: slot, x: 300, y: 200};
    sb_q.push_back(e);
    b.shooter_x = 11'd300; b.shooter_y = 11'd200;
    b.shoot = 1'b1; b.frame_tick = 1'b1;
    cyc();
    b.shoot = 1'b0; b.frame_tick = 1'b0;
    cyc();
    chk("sim_n1_busy", b.busy, 0);
    chk("sim_n1_ack", b.spawn_ack, 0);
    cyc();
    chk("sim_n2_ack", b.spawn_ack, 1);
    chk("sim_n2_busy", b.busy, 0);
    b.rd_index = IDX_W'(slot);
    #1;
    pop_and_check("sim_spawn", b.rd_x, b.rd_y, b.rd_active, idx);
    m_act[idx] = 1'b1; m_x[idx] = 300; m_y[idx] = 200;
    run = 0; ovr = 0; inj = 0; ret = 0; prev_busy = 1'b0;
    for (int k = 0; k < 60; k++) begin
      cyc();
      if (b.frame_overrun === 1'b1) ovr++;
      if (b.retire === 1'b1) ret++;
      if (b.busy === 1'b1) run++;
      else if (prev_busy) begin
        runs.push_back(run);
        run = 0;
      end
      prev_busy = (b.busy === 1'b1);
      b.frame_tick = 1'b0;
      if (b.busy === 1'b1 && inj < 2) begin
        b.frame_tick = 1'b1;
        inj++;
      end
      if (runs.size() == 2) break;
    end
    b.frame_tick = 1'b0;
    chk("sim_pass_count", runs.size(), 2);
    if (runs.size() == 2) begin
      chk("sim_run0_len", runs[0], 16);
      chk("sim_run1_len", runs[1], 16);
    end
    chk("sim_overrun", ovr, 1);
    exp_ret = 0;
    model_pass(exp_ret);
    model_pass(exp_ret);
    chk("sim_retires", ret, exp_ret);
    check_pool("sim");
    cyc();

    // Reset while the pass is working on idx 7.
    b.frame_tick = 1'b1;
    cyc();
    b.frame_tick = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (b.busy === 1'b1) break;
    end
    chk("mid_busy", b.busy, 1);
    repeat (7) cyc();
    Reset = 1'b1;
    cyc();
    chk("mid_rst_busy", b.busy, 0);
    chk("mid_rst_mask", b.active_mask, 0);
    chk("mid_rst_count", b.active_count, 0);
    b.rd_index = '0;
    #1;
    chk("mid_rst_rd", {b.rd_active, b.rd_x, b.rd_y}, 0);
    Reset = 1'b0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      m_act[i] = 1'b0; m_x[i] = 0; m_y[i] = 0;
    end
    cyc();
    check_pool("mid_rst");
    cyc();
    do_shoot(10, 20, 1'b1);
    check_pool("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pellet_pool_ctrl.md
Name: pellet_pool_ctrl

Overview:
Owns the 16-entry player pellet pool for the Doodle Jump playfield (640x480). It allocates a free slot when the player shoots and advances every live pellet once per video frame. It retires pellets that leave the top of the screen. A read port lets the sprite/draw logic fetch any slot, so the pellet storage is sequenced by one controller rather than by ad-hoc Shoot logic.

Parameters:
NUM_SLOTS, 16, pool depth; must be a power of two, index width IDX_W = log2(NUM_SLOTS).
SPEED, 11'd4, pixels a pellet rises per frame.
COOLDOWN_FRAMES, 4'd8, frames after a successful spawn during which shoot is ignored.

Ports:
Clk  in  1  system clock.
Reset  in  1  synchronous, active-high.
frame_tick  in  1  one-cycle pulse per frame, issued at vblank start.
shoot  in  1  one-cycle fire request from player input.
shooter_x  in  11  spawn x, sampled when the spawn executes.
shooter_y  in  11  spawn y, sampled when the spawn executes.
rd_index  in  IDX_W  renderer slot select.
rd_active  out  1  slot rd_index live (combinational read).
rd_x  out  11  slot rd_index x (combinational read).
rd_y  out  11  slot rd_index y (combinational read).
active_mask  out  NUM_SLOTS  bit i = slot i live.
active_count  out  5  popcount of active_mask.
busy  out  1  high while in UPDATE.
spawn_ack  out  1  one-cycle pulse: a pellet was written.
shoot_drop  out  1  one-cycle pulse: accepted shoot found pool full.
retire  out  1  one-cycle pulse per pellet retired.
frame_overrun  out  1  one-cycle pulse: frame_tick arrived while one was already pending.

Behaviour:
- Reset: every slot has active=0, x=0, y=0. State IDLE. shoot_pend=0, frame_pend=0, cooldown=0. All pulse outputs and busy are 0. Reset mid-UPDATE aborts the pass with no partial-state requirement beyond these values.
- shoot accept: shoot=1 and cooldown==0 and shoot_pend==0 sets shoot_pend. Any other shoot is ignored silently. Acceptance is legal in any state.
- frame_tick:
  - Sets frame_pend. If frame_pend is already 1, the tick is discarded and frame_overrun pulses.
  - On every frame_tick, cooldown decrements when nonzero, independent of state.
- FSM states: IDLE, SPAWN, UPDATE.
- IDLE priority: shoot_pend first, then frame_pend.
  - shoot_pend -> SPAWN.
  - else frame_pend -> UPDATE; clear frame_pend, idx=0.
- SPAWN, single cycle:
  - Take the lowest-index inactive slot.
  - If one exists: write active=1, x=shooter_x, y=shooter_y; pulse spawn_ack; cooldown=COOLDOWN_FRAMES.
  - If none: pulse shoot_drop; cooldown unchanged.
  - Clear shoot_pend in both cases; -> IDLE.
- Spawn latency: shoot sampled at edge N sets shoot_pend at N. SPAWN runs at N+1; the slot write and spawn_ack land at edge N+2.
- UPDATE: one slot per cycle, idx 0..NUM_SLOTS-1, so 16 cycles; busy=1 throughout.
  - Inactive slot: unchanged.
  - Active slot with y < SPEED: active=0 and retire pulses.
  - Otherwise: y = y - SPEED (11-bit, no wrap possible). x is never modified.
  - After idx=NUM_SLOTS-1 -> IDLE. idx wraps to 0.
- shoot during UPDATE is latched and serviced after the pass.
- frame_tick during UPDATE sets frame_pend, so a second pass follows immediately.
- Simultaneous shoot+frame_tick in IDLE: both latched; spawn executes first, update second.
- A pellet spawned this frame is moved on the next pass only if the spawn precedes that pass.
- Read port and active_mask reflect registered slot state. active_count is combinational from active_mask.

Decomposition:
- Package pellet_pkg holds:
  - NUM_SLOTS, IDX_W, SCREEN_W=640, SCREEN_H=480.
  - typedef enum {IDLE, SPAWN, UPDATE} pellet_state_t.
  - typedef struct packed {logic active; logic [10:0] x; logic [10:0] y;} pellet_t.
- One sub-module: pellet_free_finder. It is a combinational lowest-zero priority encoder over active_mask and outputs found (1b) and free_idx (IDX_W).

Test Plan:
- Reset, then shoot with shooter=(100,300) -> spawn_ack 2 edges later; slot0=(1,100,300); active_count=1; cooldown=8.
- After spawn, 8 frame_ticks (slot0 y 300->268); shoot -> accepted; slot1 written; slot0 stays at x=100.
- Spawn at y=6, SPEED 4 -> after tick1 y=2; tick2 -> retire pulse, slot inactive, active_count decrements.
- Fill all 16 slots (COOLDOWN_FRAMES=0 build), shoot again -> shoot_drop pulses; no slot changes; retire slot 5, shoot -> slot 5 reused.
- Same-cycle shoot+frame_tick in IDLE -> SPAWN first, then 16-cycle UPDATE with busy high for exactly 16 cycles. frame_tick during UPDATE -> second pass; a third tick while pending -> frame_overrun.
- Reset asserted mid-UPDATE at idx=7 -> next cycle all slots inactive, busy=0, state IDLE.
